// File: rtl/uart_pkg.sv
// uart_pkg
//   Types and constants shared by the UART controller blocks.
//   uart_mode_t       : payload selection carried in the mode byte of a frame.
//   packer_state_t    : state encoding of uart_frame_packer; it is exported on a
//                       debug port so checkers can follow the frame position.
//   UART_SYNC_DEFAULT : default first byte of every frame.
package uart_pkg;

  typedef enum logic [1:0] {
    MIXED = 2'b00,
    RAW   = 2'b01,
    ENC   = 2'b10
  } uart_mode_t;

  // 2'b11 is the one mode encoding that is rejected at acceptance.
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  localparam logic [7:0] UART_SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    MODE = 3'd2,
    HDR  = 3'd3,
    PAY0 = 3'd4,
    PAY1 = 3'd5,
    CSUM = 3'd6
  } packer_state_t;

endpackage

// File: rtl/uart_frame_packer.sv
// uart_frame_packer
//   Takes one header plus an encrypted/decrypted message pair per transaction
//   and serialises it as a byte stream for uart_tx:
//     SYNC_BYTE, {6'b0,mode}, header (MSB first), payload, XOR checksum.
//   Payload: RAW -> decrypted, ENC -> encrypted, MIXED -> encrypted then
//   decrypted. The checksum covers every byte from the mode byte through the
//   last payload byte.
//
// Handshakes: both sides use valid/ready. A transfer happens on a rising edge
// where valid and ready are both 1. Once valid is raised, the data and valid
// stay stable until that transfer. Valid never depends on ready.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-low reset
//   valid_in / ready_out  upstream message handshake (ready_out only in IDLE)
//   encrypted_in          ciphertext, MESSAGE_SIZE bits
//   decrypted_in          plaintext, MESSAGE_SIZE bits
//   header_in             header, HEADER_SIZE bits
//   mode_in               2'b00 MIXED, 2'b01 RAW, 2'b10 ENC, 2'b11 illegal
//   byte_out / byte_valid_out / byte_ready_in   registered byte stream to uart_tx
//   busy_out              a frame is in progress
//   err_mode_out          one-cycle pulse when an illegal mode is accepted
//   state_out             current FSM state (debug)
module uart_frame_packer
  import uart_pkg::*;
#(
  parameter int          MESSAGE_SIZE = 512,
  parameter int          HEADER_SIZE  = 32,
  parameter logic [7:0]  SYNC_BYTE    = UART_SYNC_DEFAULT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [MESSAGE_SIZE-1:0] encrypted_in,
  input  logic [MESSAGE_SIZE-1:0] decrypted_in,
  input  logic [HEADER_SIZE-1:0]  header_in,
  input  logic [1:0]              mode_in,
  output logic [7:0]              byte_out,
  output logic                    byte_valid_out,
  input  logic                    byte_ready_in,
  output logic                    busy_out,
  output logic                    err_mode_out,
  output packer_state_t           state_out
);

  localparam int HDR_BYTES = HEADER_SIZE / 8;
  localparam int MSG_BYTES = MESSAGE_SIZE / 8;
  localparam int MAX_BYTES = (HDR_BYTES > MSG_BYTES) ? HDR_BYTES : MSG_BYTES;
  localparam int CNT_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int HOFF_W    = (HEADER_SIZE > 8) ? $clog2(HEADER_SIZE) : 1;
  localparam int MOFF_W    = (MESSAGE_SIZE > 8) ? $clog2(MESSAGE_SIZE) : 1;

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BYTES - 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BYTES - 1);

  packer_state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [7:0]       csum, csum_d;
  logic [7:0]       byte_d;
  logic             valid_d;
  logic             err_d;
  logic             accept;
  logic             hs;

  logic [HEADER_SIZE-1:0]  hdr_q;
  logic [MESSAGE_SIZE-1:0] enc_q;
  logic [MESSAGE_SIZE-1:0] dec_q;
  logic [1:0]              mode_q;

  logic [HOFF_W-1:0] hdr_off;
  logic [MOFF_W-1:0] msg_off;

  assign hs        = byte_valid_out && byte_ready_in;
  assign ready_out = (state == IDLE);
  assign busy_out  = (state != IDLE);
  assign state_out = state;

  // Next state, counter and checksum.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    csum_d  = csum;
    err_d   = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in) begin
          accept = 1'b1;
          cnt_d  = '0;
          csum_d = 8'h00;
          if (mode_in == MODE_ILLEGAL) err_d   = 1'b1;
          else                         state_d = SYNC;
        end
      end
      SYNC: if (hs) state_d = MODE;
      MODE: begin
        if (hs) begin
          csum_d  = csum ^ byte_out;
          state_d = HDR;
        end
      end
      HDR: begin
        if (hs) begin
          csum_d = csum ^ byte_out;
          if (cnt == HDR_LAST) begin
            cnt_d   = '0;
            state_d = PAY0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      PAY0: begin
        if (hs) begin
          csum_d = csum ^ byte_out;
          if (cnt == MSG_LAST) begin
            cnt_d   = '0;
            state_d = (mode_q == MIXED) ? PAY1 : CSUM;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      PAY1: begin
        if (hs) begin
          csum_d = csum ^ byte_out;
          if (cnt == MSG_LAST) begin
            cnt_d   = '0;
            state_d = CSUM;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      CSUM: if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The output byte is registered: it is chosen from the *next* state and
  // counter so the new byte appears in the same cycle the state advances.
  // While stalled it is simply held.
  always_comb begin
    byte_d  = byte_out;
    valid_d = (state_d != IDLE);
    hdr_off = HOFF_W'(8 * (HDR_BYTES - 1 - int'(cnt_d)));
    msg_off = MOFF_W'(8 * (MSG_BYTES - 1 - int'(cnt_d)));
    if (hs || accept) begin
      case (state_d)
        SYNC:    byte_d = SYNC_BYTE;
        MODE:    byte_d = {6'b0, mode_q};
        HDR:     byte_d = hdr_q[hdr_off +: 8];
        PAY0:    byte_d = (mode_q == RAW) ? dec_q[msg_off +: 8] : enc_q[msg_off +: 8];
        PAY1:    byte_d = dec_q[msg_off +: 8];
        // csum_d already includes the final payload byte.
        CSUM:    byte_d = csum_d;
        default: byte_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      cnt            <= '0;
      csum           <= 8'h00;
      byte_out       <= 8'h00;
      byte_valid_out <= 1'b0;
      err_mode_out   <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      csum           <= csum_d;
      byte_out       <= byte_d;
      byte_valid_out <= valid_d;
      err_mode_out   <= err_d;
    end
  end

  // Transaction capture: later changes on the inputs never reach the frame.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hdr_q  <= '0;
      enc_q  <= '0;
      dec_q  <= '0;
      mode_q <= 2'b00;
    end else if (accept) begin
      hdr_q  <= header_in;
      enc_q  <= encrypted_in;
      dec_q  <= decrypted_in;
      mode_q <= mode_in;
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Testbench for uart_frame_packer: a small instance (M=16, H=16) driven from a
// table of hand-computed frames, and a default-size instance (M=512, H=32)
// for frame length and mid-frame reset.
module tb_uart_frame_packer;
  import uart_pkg::*;

  localparam int SM = 16;
  localparam int SH = 16;
  localparam int BM = 512;
  localparam int BH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic s_rst, b_rst;

  // ---------------- DUT signals ----------------
  logic          s_valid, b_valid;
  logic [1:0]    mode;
  logic          byte_ready;
  logic [SM-1:0] s_enc, s_dec;
  logic [SH-1:0] s_hdr;
  logic [BM-1:0] b_enc, b_dec;
  logic [BH-1:0] b_hdr;

  logic          s_ready, s_bval, s_busy, s_err;
  logic [7:0]    s_byte;
  packer_state_t s_state;
  logic          b_ready, b_bval, b_busy, b_err;
  logic [7:0]    b_byte;
  packer_state_t b_state;

  uart_frame_packer #(.MESSAGE_SIZE(SM), .HEADER_SIZE(SH)) dut_small (
    .clk_in(clk), .rst_in(s_rst), .valid_in(s_valid), .ready_out(s_ready),
    .encrypted_in(s_enc), .decrypted_in(s_dec), .header_in(s_hdr), .mode_in(mode),
    .byte_out(s_byte), .byte_valid_out(s_bval), .byte_ready_in(byte_ready),
    .busy_out(s_busy), .err_mode_out(s_err), .state_out(s_state)
  );

  uart_frame_packer dut_big (
    .clk_in(clk), .rst_in(b_rst), .valid_in(b_valid), .ready_out(b_ready),
    .encrypted_in(b_enc), .decrypted_in(b_dec), .header_in(b_hdr), .mode_in(mode),
    .byte_out(b_byte), .byte_valid_out(b_bval), .byte_ready_in(byte_ready),
    .busy_out(b_busy), .err_mode_out(b_err), .state_out(b_state)
  );

  // Selects which instance the frame monitor looks at.
  bit use_big = 1'b0;
  wire [7:0] cur_byte  = use_big ? b_byte  : s_byte;
  wire       cur_bval  = use_big ? b_bval  : s_bval;
  wire       cur_ready = use_big ? b_ready : s_ready;
  wire       cur_busy  = use_big ? b_busy  : s_busy;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at the falling edge of the cycle after acceptance. Consumes the
  // byte stream against exp_q; stop_after > 0 leaves early, mid-frame.
  task automatic run_frame(input bit bp, input int stop_after, output int nbytes);
    int         cycles;
    bit         done;
    bit         prev_stall;
    logic [7:0] prev_byte;
    logic [7:0] e;
    cycles = 0; done = 1'b0; prev_stall = 1'b0; prev_byte = 8'h00; nbytes = 0;
    chk("first_valid", 32'(cur_bval), 32'd1);
    chk("first_busy", 32'(cur_busy), 32'd1);
    chk("ready_low", 32'(cur_ready), 32'd0);
    while (!done && cycles < 4000) begin
      byte_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        chk("hold_byte", 32'(cur_byte), 32'(prev_byte));
        chk("hold_valid", 32'(cur_bval), 32'd1);
      end
      if (cur_ready) chk("ready_in_frame", 32'(cur_ready), 32'd0);
      if (cur_bval && byte_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_byte: got %0h expected none", cur_byte);
          done = 1'b1;
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("byte%0d", nbytes), 32'(cur_byte), 32'(e));
          nbytes++;
          if (exp_q.size() == 0) done = 1'b1;
          if (stop_after > 0 && nbytes == stop_after) return;
        end
      end
      prev_stall = cur_bval && !byte_ready;
      prev_byte  = cur_byte;
      @(negedge clk);
      cycles++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: got %0d bytes expected %0d more", nbytes, exp_q.size());
      exp_q.delete();
    end
    // Cycle after the checksum handshake.
    chk("end_ready", 32'(cur_ready), 32'd1);
    chk("end_valid", 32'(cur_bval), 32'd0);
    chk("end_busy", 32'(cur_busy), 32'd0);
    if (!bp) chk("no_bubbles", 32'(cycles), 32'(nbytes));
  endtask

  // Independent model of a default-size frame built from the big-instance inputs.
  task automatic push_big(input logic [1:0] m);
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back({6'b0, m});
    cs ^= {6'b0, m};
    for (int k = 0; k < BH / 8; k++) begin
      b = 8'(b_hdr >> (BH - 8 - 8 * k));
      exp_q.push_back(b);
      cs ^= b;
    end
    for (int k = 0; k < BM / 8; k++) begin
      b = (m == 2'b01) ? 8'(b_dec >> (BM - 8 - 8 * k)) : 8'(b_enc >> (BM - 8 - 8 * k));
      exp_q.push_back(b);
      cs ^= b;
    end
    if (m == 2'b00) begin
      for (int k = 0; k < BM / 8; k++) begin
        b = 8'(b_dec >> (BM - 8 - 8 * k));
        exp_q.push_back(b);
        cs ^= b;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic fill_big(input logic [31:0] hdr);
    b_hdr = hdr;
    for (int k = 0; k < BM / 32; k++) begin
      b_enc[32*k +: 32] = $urandom;
      b_dec[32*k +: 32] = $urandom;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] hdr;
    logic [15:0] enc;
    logic [15:0] dec;
    bit          bp;
    int          len;
    logic [7:0]  b[9];
  } vec_t;

  vec_t vt[5];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;

    vt[0].mode = 2'b01; vt[0].hdr = 16'h1234; vt[0].enc = 16'h5555; vt[0].dec = 16'hABCD;
    vt[0].bp = 1'b0; vt[0].len = 7;
    vt[0].b = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 8'h00, 8'h00};
    vt[1].mode = 2'b10; vt[1].hdr = 16'h0000; vt[1].enc = 16'h0F0F; vt[1].dec = 16'h7777;
    vt[1].bp = 1'b0; vt[1].len = 7;
    vt[1].b = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'h02, 8'h00, 8'h00};
    vt[2].mode = 2'b00; vt[2].hdr = 16'hFFFF; vt[2].enc = 16'h0102; vt[2].dec = 16'h0304;
    vt[2].bp = 1'b0; vt[2].len = 9;
    vt[2].b = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    vt[3] = vt[0];
    vt[3].bp = 1'b1;
    vt[4].mode = 2'b01; vt[4].hdr = 16'h00FF; vt[4].enc = 16'hEEEE; vt[4].dec = 16'h8001;
    vt[4].bp = 1'b0; vt[4].len = 7;
    vt[4].b = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h7F, 8'h00, 8'h00};

    s_rst = 1'b0; b_rst = 1'b0;
    s_valid = 1'b0; b_valid = 1'b0; mode = 2'b00; byte_ready = 1'b1;
    s_enc = '0; s_dec = '0; s_hdr = '0; b_enc = '0; b_dec = '0; b_hdr = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_valid", 32'(s_bval), 32'd0);
    chk("rst_byte", 32'(s_byte), 32'h00);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_err", 32'(s_err), 32'd0);
    chk("rst_state", 32'(s_state), 32'(IDLE));
    chk("rst_big_ready", 32'(b_ready), 32'd1);
    chk("rst_big_valid", 32'(b_bval), 32'd0);
    s_rst = 1'b1; b_rst = 1'b1;
    @(negedge clk);

    // Table frames, back-to-back: each new message is offered in the cycle
    // right after the previous checksum handshake.
    use_big = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_hdr = vt[i].hdr; s_enc = vt[i].enc; s_dec = vt[i].dec; mode = vt[i].mode;
      s_valid = 1'b1;
      chk("accept_ready", 32'(s_ready), 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
      s_hdr = 16'($urandom); s_enc = 16'($urandom); s_dec = 16'($urandom);
      mode = 2'($urandom_range(0, 3));
      for (int k = 0; k < vt[i].len; k++) exp_q.push_back(vt[i].b[k]);
      run_frame(vt[i].bp, 0, n);
      chk($sformatf("frame%0d_len", i), 32'(n), 32'(vt[i].len));
    end

    // Illegal mode: error pulse only, nothing transmitted.
    mode = 2'b11; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; mode = 2'b00;
    chk("illegal_err", 32'(s_err), 32'd1);
    chk("illegal_ready", 32'(s_ready), 32'd1);
    chk("illegal_valid", 32'(s_bval), 32'd0);
    chk("illegal_busy", 32'(s_busy), 32'd0);
    @(negedge clk);
    chk("illegal_err_clear", 32'(s_err), 32'd0);
    chk("illegal_valid2", 32'(s_bval), 32'd0);

    // Default size, MIXED frame.
    use_big = 1'b1;
    fill_big(32'hDEADBEEF);
    mode = 2'b00;
    push_big(2'b00);
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0; b_hdr = '0; b_enc = '0;
    run_frame(1'b0, 0, n);
    chk("big_mixed_len", 32'(n), 32'd135);

    // Reset after byte 20 of a RAW frame, then a clean frame.
    fill_big(32'h01020304);
    mode = 2'b01;
    push_big(2'b01);
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    run_frame(1'b0, 20, n);
    @(posedge clk);
    #2 b_rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(b_bval), 32'd0);
    chk("midrst_ready", 32'(b_ready), 32'd1);
    chk("midrst_busy", 32'(b_busy), 32'd0);
    chk("midrst_byte", 32'(b_byte), 32'h00);
    chk("midrst_state", 32'(b_state), 32'(IDLE));
    exp_q.delete();
    @(negedge clk);
    b_rst = 1'b1;
    @(negedge clk);
    fill_big(32'hCAFEF00D);
    mode = 2'b10;
    push_big(2'b10);
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    run_frame(1'b0, 0, n);
    chk("big_after_rst_len", 32'(n), 32'd71);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_packer.md
# uart_frame_packer

- Parametrised successor to the UART TX bridge.
- Accepts one header plus encrypted/decrypted message pair per transaction and serialises it into a framed byte stream for the byte-level `uart_tx`.
- Frame: sync byte, mode byte, header, payload selected by mode (RAW, ENC, or MIXED = both), trailing XOR checksum.
- Sits between the crypto datapath and `uart_tx` inside the UART controller.

## Interface
- `MESSAGE_SIZE`, default 512, message width in bits; must be a multiple of 8.
- `HEADER_SIZE`, default 32, header width in bits; must be a multiple of 8.
- `SYNC_BYTE`, default 8'hA5, first byte of every frame.
- `clk_in` input 1: single clock.
- `rst_in` input 1: reset, asynchronous, active-low.
- `valid_in` input 1: upstream message valid.
- `ready_out` output 1: block can accept a message.
- `encrypted_in` input MESSAGE_SIZE: ciphertext.
- `decrypted_in` input MESSAGE_SIZE: plaintext.
- `header_in` input HEADER_SIZE: header.
- `mode_in` input 2: 2'b00 MIXED, 2'b01 RAW, 2'b10 ENC, 2'b11 illegal.
- `byte_out` output 8: byte to `uart_tx`.
- `byte_valid_out` output 1: `byte_out` valid.
- `byte_ready_in` input 1: `uart_tx` ready.
- `busy_out` output 1: a frame is in progress.
- `err_mode_out` output 1: one-cycle pulse when an illegal mode is accepted.

## Operation
- **States:** IDLE, SYNC, MODE, HDR, PAY0, PAY1, CSUM.
- **Accept:** a message is accepted on `valid_in && ready_out`. On that edge, latch header, both messages and mode; clear the checksum accumulator and byte counter.
  - Legal mode: go to SYNC.
  - Mode 2'b11: stay in IDLE and pulse `err_mode_out` for 1 cycle; nothing is transmitted.
- **Byte order** (each state advances only on the `byte_valid_out && byte_ready_in` handshake):
  - SYNC: `SYNC_BYTE`.
  - MODE: {6'b0, mode}.
  - HDR: HEADER_SIZE/8 bytes, MSB first.
  - PAY0: MESSAGE_SIZE/8 bytes, MSB first. Source is `decrypted_in` for RAW, `encrypted_in` for ENC and MIXED.
  - PAY1: MIXED only; MESSAGE_SIZE/8 bytes of `decrypted_in`, MSB first.
  - CSUM: XOR of every byte from MODE through the last payload byte (SYNC excluded).
- **Frame length:** RAW/ENC = 3 + H/8 + M/8 bytes (71 with defaults); MIXED = 3 + H/8 + 2·M/8 bytes (135 with defaults).
- **Byte counter:** width $clog2(max(H,M)/8). Reset to 0 at each state change; the state changes when the counter reaches last-index and that byte handshakes.
- **Checksum:** 8-bit register, XOR-accumulated on each handshaked byte in MODE/HDR/PAY0/PAY1.
- **Inputs:** ignored outside IDLE. Input changes after acceptance do not affect the frame.

## Timing
- **Reset values:** `ready_out`=1, `byte_valid_out`=0, `byte_out`=8'h00, `busy_out`=0, `err_mode_out`=0; state IDLE.
- **Acceptance latency:** acceptance at edge N gives `byte_valid_out`=1 with `SYNC_BYTE` from cycle N+1. `busy_out`=1 from N+1 until the CSUM handshake edge.
- **Output hold:** `byte_out` and `byte_valid_out` are registered and held stable while `byte_ready_in`=0.
- **Throughput:** with `byte_ready_in` tied high, one byte per cycle and no bubbles between states.
- **Frame end:** the CSUM handshake at edge K gives `ready_out`=1 and `byte_valid_out`=0 in cycle K+1. `ready_out` is 0 throughout a frame.
- **Back-to-back:** a new message can be accepted in cycle K+1; its SYNC appears in K+2.
- **Reset mid-frame:** outputs return to reset values immediately, asynchronously. The partial frame is dropped, not resumed.

## Structure
- Shared package `uart_pkg`:
  - `uart_mode_t` enum (MIXED=2'b00, RAW=2'b01, ENC=2'b10).
  - `UART_SYNC_DEFAULT` = 8'hA5.
  - `packer_state_t` enum.
- No sub-module. Byte selection uses indexed part-select on the latched vectors; the checksum is inline.

## Test plan
Use M=16, H=16 unless stated.
- **RAW:** header 16'h1234, decrypted 16'hABCD, `byte_ready_in`=1 → bytes A5,01,12,34,AB,CD,41 on consecutive cycles; `ready_out` returns 1 the cycle after 41.
- **ENC:** header 16'h0000, encrypted 16'h0F0F → A5,02,00,00,0F,0F,02.
- **MIXED:** header 16'hFFFF, encrypted 16'h0102, decrypted 16'h0304 → A5,00,FF,FF,01,02,03,04,04.
- **Backpressure:** RAW frame with `byte_ready_in` toggling randomly → same byte sequence; `byte_out` stable while stalled.
- **Illegal mode 2'b11:** → `err_mode_out` pulses 1 cycle, no `byte_valid_out`, `ready_out` stays 1.
- **Defaults (M=512, H=32):**
  - MIXED frame → 135 bytes.
  - Assert `rst_in` low after byte 20 → `byte_valid_out`=0 immediately. The next frame starts cleanly with A5.
